// File: rtl/ex_mem_stage.sv
// Execute stage of the pipelined LEGv8 CPU with its EX/MEM pipeline latch.
// Holds operand forwarding, the ALU/shifter, the branch adder and the NZCV flag register.
module ex_mem_stage #(
  parameter int WIDTH = 64,
  parameter int RADDR = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             flush,
  input  logic [WIDTH-1:0] RD1_in,
  input  logic [WIDTH-1:0] RD2_in,
  input  logic [WIDTH-1:0] PCaddr_in,
  input  logic [WIDTH-1:0] se_in,
  input  logic [RADDR-1:0] Rd_in,
  input  logic [5:0]       cntrl_EX_in,
  input  logic [4:0]       cntrl_M_in,
  input  logic [1:0]       cntrl_WB_in,
  input  logic [1:0]       fwdA,
  input  logic [1:0]       fwdB,
  input  logic [WIDTH-1:0] wb_data,
  output logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] store_data,
  output logic [WIDTH-1:0] br_target,
  output logic             zero_out,
  output logic [RADDR-1:0] Rd_out,
  output logic [4:0]       cntrl_M_out,
  output logic [1:0]       cntrl_WB_out,
  output logic [3:0]       flags
);

  typedef enum logic [2:0] {
    OP_PASS  = 3'b000,
    OP_ZERO  = 3'b001,
    OP_ADD   = 3'b010,
    OP_SUB   = 3'b011,
    OP_AND   = 3'b100,
    OP_OR    = 3'b101,
    OP_XOR   = 3'b110,
    OP_SHIFT = 3'b111
  } alu_op_e;

  logic       alu_src;
  logic       shift_right;
  logic       flag_en;
  alu_op_e    alu_op;

  assign alu_src     = cntrl_EX_in[5];
  assign shift_right = cntrl_EX_in[4];
  assign flag_en     = cntrl_EX_in[3];
  assign alu_op      = alu_op_e'(cntrl_EX_in[2:0]);

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_bf;
  logic [WIDTH-1:0] alu_b;

  // Forward select 01 reads the latched alu_out, so there is no combinational loop.
  always_comb begin
    case (fwdA)
      2'b01:   op_a = alu_out;
      2'b10:   op_a = wb_data;
      default: op_a = RD1_in;
    endcase
    case (fwdB)
      2'b01:   op_bf = alu_out;
      2'b10:   op_bf = wb_data;
      default: op_bf = RD2_in;
    endcase
    alu_b = alu_src ? se_in : op_bf;
  end

  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum_ext;
  logic             carry;
  logic             ovf;
  logic [5:0]       shamt;
  logic             is_sub;

  // Subtraction shares the adder as A + ~B + 1, which yields the LEGv8 carry convention.
  always_comb begin
    result  = '0;
    carry   = 1'b0;
    ovf     = 1'b0;
    is_sub  = (alu_op == OP_SUB);
    b_eff   = is_sub ? ~alu_b : alu_b;
    sum_ext = {1'b0, op_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    shamt   = alu_b[5:0];
    case (alu_op)
      OP_PASS: result = alu_b;
      OP_ZERO: result = '0;
      OP_ADD, OP_SUB: begin
        result = sum_ext[WIDTH-1:0];
        carry  = sum_ext[WIDTH];
        ovf    = (op_a[WIDTH-1] == b_eff[WIDTH-1]) &&
                 (sum_ext[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_AND:   result = op_a & alu_b;
      OP_OR:    result = op_a | alu_b;
      OP_XOR:   result = op_a ^ alu_b;
      OP_SHIFT: result = shift_right ? (op_a >> shamt) : (op_a << shamt);
      default:  result = '0;
    endcase
  end

  logic [3:0]       nzcv;
  logic [WIDTH-1:0] br_next;

  assign nzcv    = {result[WIDTH-1], (result == '0), carry, ovf};
  assign br_next = PCaddr_in + (se_in << 2);

  // Flush loads a bubble even while stalled; the flag register only moves on a real instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_out      <= '0;
      store_data   <= '0;
      br_target    <= '0;
      zero_out     <= 1'b0;
      Rd_out       <= '0;
      cntrl_M_out  <= '0;
      cntrl_WB_out <= '0;
      flags        <= '0;
    end else if (flush) begin
      alu_out      <= '0;
      store_data   <= '0;
      br_target    <= '0;
      zero_out     <= 1'b0;
      Rd_out       <= '0;
      cntrl_M_out  <= '0;
      cntrl_WB_out <= '0;
    end else if (enable) begin
      alu_out      <= result;
      store_data   <= op_bf;
      br_target    <= br_next;
      zero_out     <= (result == '0);
      Rd_out       <= Rd_in;
      cntrl_M_out  <= cntrl_M_in;
      cntrl_WB_out <= cntrl_WB_in;
      if (flag_en) begin
        flags <= nzcv;
      end
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed self-checking bench for ex_mem_stage: reset, ALU ops, flags, forwarding,
// stall/flush and shift/branch-target behaviour, each against hand-computed values.
module tb_ex_mem_stage;

  localparam int W = 64;
  localparam int R = 5;

  logic          clk;
  logic          rst;
  logic          enable;
  logic          flush;
  logic [W-1:0]  RD1_in, RD2_in, PCaddr_in, se_in, wb_data;
  logic [R-1:0]  Rd_in;
  logic [5:0]    cntrl_EX_in;
  logic [4:0]    cntrl_M_in;
  logic [1:0]    cntrl_WB_in;
  logic [1:0]    fwdA, fwdB;
  logic [W-1:0]  alu_out, store_data, br_target;
  logic          zero_out;
  logic [R-1:0]  Rd_out;
  logic [4:0]    cntrl_M_out;
  logic [1:0]    cntrl_WB_out;
  logic [3:0]    flags;

  int errors = 0;
  int checks = 0;

  ex_mem_stage #(.WIDTH(W), .RADDR(R)) dut (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush),
    .RD1_in(RD1_in), .RD2_in(RD2_in), .PCaddr_in(PCaddr_in), .se_in(se_in),
    .Rd_in(Rd_in), .cntrl_EX_in(cntrl_EX_in), .cntrl_M_in(cntrl_M_in),
    .cntrl_WB_in(cntrl_WB_in), .fwdA(fwdA), .fwdB(fwdB), .wb_data(wb_data),
    .alu_out(alu_out), .store_data(store_data), .br_target(br_target),
    .zero_out(zero_out), .Rd_out(Rd_out), .cntrl_M_out(cntrl_M_out),
    .cntrl_WB_out(cntrl_WB_out), .flags(flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic alusrc, input logic shdir, input logic flagen,
                       input logic [2:0] op, input logic [W-1:0] rd1,
                       input logic [W-1:0] rd2, input logic [W-1:0] se,
                       input logic [W-1:0] pc, input logic [R-1:0] rd,
                       input logic [4:0] m, input logic [1:0] wb,
                       input logic [1:0] fa, input logic [1:0] fb,
                       input logic [W-1:0] wbd);
    cntrl_EX_in = {alusrc, shdir, flagen, op};
    RD1_in = rd1; RD2_in = rd2; se_in = se; PCaddr_in = pc;
    Rd_in = rd; cntrl_M_in = m; cntrl_WB_in = wb;
    fwdA = fa; fwdB = fb; wb_data = wbd;
  endtask

  task automatic test_reset();
    logic [W-1:0] exp_sub;
    exp_sub = 64'hFFFF_FFFF_FFFF_FFFE;
    rst = 1'b0; enable = 1'b1; flush = 1'b0;
    drive(0, 0, 1, 3'b011, 64'd3, 64'd5, 64'd0, 64'h40, 5'd9, 5'b10000, 2'b01, 2'b00, 2'b00, 64'd0);
    #2;
    checks++;
    if ({alu_out, store_data, br_target, zero_out, Rd_out, cntrl_M_out, cntrl_WB_out, flags} !== '0) begin
      errors++; $display("[TB] FAIL reset_initial: got alu=%h flags=%b rd=%0d, expected all zero", alu_out, flags, Rd_out);
    end
    rst = 1'b1;
    step();
    checks++;
    if (alu_out !== exp_sub || flags !== 4'b1000 || Rd_out !== 5'd9) begin
      errors++; $display("[TB] FAIL reset_preload: got alu=%h flags=%b rd=%0d, expected %h 1000 9", alu_out, flags, Rd_out, exp_sub);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({alu_out, store_data, br_target, zero_out, Rd_out, cntrl_M_out, cntrl_WB_out, flags} !== '0) begin
      errors++; $display("[TB] FAIL reset_async: got alu=%h flags=%b br=%h, expected all zero", alu_out, flags, br_target);
    end
    step();
    checks++;
    if ({alu_out, flags, Rd_out} !== '0) begin
      errors++; $display("[TB] FAIL reset_held: got alu=%h flags=%b, expected zero", alu_out, flags);
    end
    rst = 1'b1;
    #2;
    checks++;
    if ({alu_out, flags, Rd_out} !== '0) begin
      errors++; $display("[TB] FAIL reset_release_wait: got alu=%h flags=%b, expected zero before edge", alu_out, flags);
    end
    step();
    checks++;
    if (alu_out !== exp_sub || flags !== 4'b1000) begin
      errors++; $display("[TB] FAIL reset_resume: got alu=%h flags=%b, expected %h 1000", alu_out, flags, exp_sub);
    end
  endtask

  task automatic test_add();
    drive(0, 0, 1, 3'b010, 64'd5, 64'd7, 64'd0, 64'h0, 5'd3, 5'b01000, 2'b11, 2'b00, 2'b00, 64'd0);
    step();
    checks++;
    if (alu_out !== 64'd12 || zero_out !== 1'b0 || flags !== 4'b0000) begin
      errors++; $display("[TB] FAIL add_basic: got alu=%0d zero=%b flags=%b, expected 12 0 0000", alu_out, zero_out, flags);
    end
    checks++;
    if (Rd_out !== 5'd3 || cntrl_M_out !== 5'b01000 || cntrl_WB_out !== 2'b11 || store_data !== 64'd7) begin
      errors++; $display("[TB] FAIL add_passthru: got rd=%0d m=%b wb=%b st=%0d, expected 3 01000 11 7", Rd_out, cntrl_M_out, cntrl_WB_out, store_data);
    end
  endtask

  task automatic test_flags();
    drive(0, 0, 1, 3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'h0, 5'd1, 5'b0, 2'b0, 2'b00, 2'b00, 64'd0);
    step();
    checks++;
    if (alu_out !== 64'h8000_0000_0000_0000 || flags !== 4'b1001) begin
      errors++; $display("[TB] FAIL add_overflow: got alu=%h flags=%b, expected 8000000000000000 1001", alu_out, flags);
    end
    drive(0, 0, 1, 3'b011, 64'd3, 64'd3, 64'd0, 64'h0, 5'd1, 5'b0, 2'b0, 2'b00, 2'b00, 64'd0);
    step();
    checks++;
    if (alu_out !== 64'd0 || zero_out !== 1'b1 || flags !== 4'b0110) begin
      errors++; $display("[TB] FAIL sub_zero: got alu=%h zero=%b flags=%b, expected 0 1 0110", alu_out, zero_out, flags);
    end
  endtask

  task automatic test_logic();
    logic [2:0]   ops [5]  = '{3'b100, 3'b101, 3'b110, 3'b000, 3'b001};
    logic [W-1:0] exps [5] = '{64'h30, 64'hFC, 64'hCC, 64'h3C, 64'h0};
    logic [3:0]   expf [5] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100};
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 1, ops[i], 64'hF0, 64'h0, 64'h3C, 64'h0, 5'd2, 5'b0, 2'b0, 2'b00, 2'b00, 64'd0);
      step();
      checks++;
      if (alu_out !== exps[i] || flags !== expf[i] || zero_out !== (exps[i] == 0)) begin
        errors++; $display("[TB] FAIL logic_op%b: got alu=%h flags=%b zero=%b, expected %h %b", ops[i], alu_out, flags, zero_out, exps[i], expf[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    drive(0, 0, 0, 3'b010, 64'd5, 64'd7, 64'd0, 64'h0, 5'd4, 5'b0, 2'b0, 2'b00, 2'b00, 64'd0);
    step();
    checks++;
    if (alu_out !== 64'd12) begin
      errors++; $display("[TB] FAIL b2b_first: got %0d, expected 12", alu_out);
    end
    drive(1, 0, 0, 3'b010, 64'd99, 64'h55, 64'd4, 64'h0, 5'd5, 5'b0, 2'b0, 2'b01, 2'b10, 64'h20);
    step();
    checks++;
    if (alu_out !== 64'd16 || store_data !== 64'h20) begin
      errors++; $display("[TB] FAIL b2b_forward: got alu=%0d st=%h, expected 16 20", alu_out, store_data);
    end
    drive(0, 0, 0, 3'b010, 64'd1, 64'd2, 64'd0, 64'h0, 5'd5, 5'b0, 2'b0, 2'b11, 2'b11, 64'h20);
    step();
    checks++;
    if (alu_out !== 64'd3 || store_data !== 64'd2) begin
      errors++; $display("[TB] FAIL fwd_reserved: got alu=%0d st=%0d, expected 3 2", alu_out, store_data);
    end
  endtask

  task automatic test_stall_flush();
    logic [W-1:0] exp_alu;
    exp_alu = 64'hFFFF_FFFF_FFFF_FFFE;
    drive(0, 0, 1, 3'b011, 64'd3, 64'd5, 64'd1, 64'h200, 5'd7, 5'b10101, 2'b11, 2'b00, 2'b00, 64'd0);
    step();
    checks++;
    if (alu_out !== exp_alu || br_target !== 64'h204 || flags !== 4'b1000 || store_data !== 64'd5) begin
      errors++; $display("[TB] FAIL stall_setup: got alu=%h br=%h flags=%b st=%0d", alu_out, br_target, flags, store_data);
    end
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 3'b011, 64'(i), 64'(i), 64'(i + 8), 64'h900, 5'(i + 20), 5'b01010, 2'b00, 2'b00, 2'b00, 64'd0);
      step();
      checks++;
      if (alu_out !== exp_alu || br_target !== 64'h204 || flags !== 4'b1000 || store_data !== 64'd5 ||
          Rd_out !== 5'd7 || cntrl_M_out !== 5'b10101 || cntrl_WB_out !== 2'b11 || zero_out !== 1'b0) begin
        errors++; $display("[TB] FAIL stall_hold%0d: got alu=%h br=%h flags=%b rd=%0d m=%b", i, alu_out, br_target, flags, Rd_out, cntrl_M_out);
      end
    end
    flush = 1'b1;
    drive(0, 0, 1, 3'b010, 64'd0, 64'd0, 64'd3, 64'h900, 5'd30, 5'b11111, 2'b11, 2'b00, 2'b00, 64'd0);
    step();
    checks++;
    if ({alu_out, store_data, br_target, zero_out, Rd_out, cntrl_M_out, cntrl_WB_out} !== '0 || flags !== 4'b1000) begin
      errors++; $display("[TB] FAIL flush_stalled: got alu=%h rd=%0d m=%b wb=%b flags=%b, expected zeros flags 1000", alu_out, Rd_out, cntrl_M_out, cntrl_WB_out, flags);
    end
    enable = 1'b1;
    drive(0, 0, 1, 3'b010, 64'd4, 64'd4, 64'd3, 64'h900, 5'd30, 5'b11111, 2'b11, 2'b00, 2'b00, 64'd0);
    step();
    checks++;
    if ({alu_out, br_target, Rd_out, cntrl_M_out, cntrl_WB_out} !== '0 || flags !== 4'b1000) begin
      errors++; $display("[TB] FAIL flush_enabled: got alu=%h rd=%0d m=%b flags=%b, expected zeros flags 1000", alu_out, Rd_out, cntrl_M_out, flags);
    end
    flush = 1'b0;
  endtask

  task automatic test_shift_branch();
    drive(0, 1, 1, 3'b111, 64'h80, 64'd3, -64'sd2, 64'h100, 5'd6, 5'b0, 2'b0, 2'b00, 2'b00, 64'd0);
    step();
    checks++;
    if (br_target !== 64'hF8 || alu_out !== 64'h10 || flags !== 4'b0000) begin
      errors++; $display("[TB] FAIL shift_right_br: got br=%h alu=%h flags=%b, expected f8 10 0000", br_target, alu_out, flags);
    end
    drive(1, 0, 1, 3'b111, 64'h80, 64'd0, 64'd67, 64'h100, 5'd6, 5'b0, 2'b0, 2'b00, 2'b00, 64'd0);
    step();
    checks++;
    if (alu_out !== 64'h400 || br_target !== 64'h20C) begin
      errors++; $display("[TB] FAIL shift_left_mod64: got alu=%h br=%h, expected 400 20c", alu_out, br_target);
    end
    drive(0, 0, 1, 3'b111, 64'h1234, 64'h40, 64'd0, 64'h0, 5'd6, 5'b0, 2'b0, 2'b00, 2'b00, 64'd0);
    step();
    checks++;
    if (alu_out !== 64'h1234) begin
      errors++; $display("[TB] FAIL shift_zero: got %h, expected 1234", alu_out);
    end
    drive(0, 0, 1, 3'b111, 64'd1, 64'd63, 64'd0, 64'h0, 5'd6, 5'b0, 2'b0, 2'b00, 2'b00, 64'd0);
    step();
    checks++;
    if (alu_out !== 64'h8000_0000_0000_0000 || flags !== 4'b1000) begin
      errors++; $display("[TB] FAIL shift_msb_flags: got alu=%h flags=%b, expected 8000000000000000 1000", alu_out, flags);
    end
    drive(0, 0, 0, 3'b001, 64'd9, 64'd9, 64'd0, 64'h0, 5'd6, 5'b0, 2'b0, 2'b00, 2'b00, 64'd0);
    step();
    checks++;
    if (alu_out !== 64'd0 || zero_out !== 1'b1 || flags !== 4'b1000) begin
      errors++; $display("[TB] FAIL flagen_off: got alu=%h zero=%b flags=%b, expected 0 1 1000", alu_out, zero_out, flags);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_flags();
    test_logic();
    test_back_to_back();
    test_stall_flush();
    test_shift_branch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Execute stage plus EX/MEM pipeline latch of the pipelined LEGv8 CPU; directly consumes the ID/EX register outputs.
- Selects forwarded operands, performs the ALU/shift operation, computes the branch target, maintains the NZCV flag register, and registers everything the MEM stage needs.
- Supports stall (hold) and flush (bubble insertion) from the hazard unit.

Parameters:
- WIDTH, 64, datapath width.
- RADDR, 5, register-index width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  1 = latch advances; 0 = hold all state (stall).
- flush  in  1  1 = next latched entry is a bubble.
- RD1_in, RD2_in  in  WIDTH  register operands from ID/EX.
- PCaddr_in  in  WIDTH  PC of the instruction.
- se_in  in  WIDTH  sign-extended immediate.
- Rd_in  in  RADDR  destination register.
- cntrl_EX_in  in  6  {ALUsrc, ShiftDir, FlagEn, ALUOp[2:0]}.
- cntrl_M_in  in  5  {MemRead, MemWrite, UBranch, Branch, Brsel}.
- cntrl_WB_in  in  2  MemtoReg/RegWrite bits.
- fwdA, fwdB  in  2  forward select: 00 ID/EX value, 01 alu_out (this block's EX/MEM result), 10 wb_data, 11 reserved (treated as 00).
- wb_data  in  WIDTH  MEM/WB write-back value.
- alu_out  out  WIDTH  latched ALU result.
- store_data  out  WIDTH  latched forwarded operand B (pre-ALUsrc mux).
- br_target  out  WIDTH  latched PCaddr_in + (se_in << 2), wraps mod 2^WIDTH.
- zero_out  out  1  latched (ALU result == 0).
- Rd_out  out  RADDR  latched Rd.
- cntrl_M_out  out  5  latched M controls.
- cntrl_WB_out  out  2  latched WB controls.
- flags  out  4  NZCV register {N,Z,C,V}.

Behaviour:
- Reset (rst = 0, asynchronous): all outputs and flags go to 0 immediately, including mid-stall. Release is synchronous to the next clk edge.
- Operand A = fwdA-selected RD1_in. Operand Bf = fwdB-selected RD2_in; Bf feeds store_data. ALU input B = ALUsrc ? se_in : Bf.
- ALUOp encoding:
  - 000: pass B.
  - 010: A + B.
  - 011: A - B, computed as A + ~B + 1.
  - 100: A & B.
  - 101: A | B.
  - 110: A ^ B.
  - 111: shift A by B[5:0]; ShiftDir 0 = logical left, 1 = logical right; shift by 0 returns A.
  - 001: result 0.
- Flags are computed combinationally from the result:
  - N = result[WIDTH-1]; Z = (result == 0).
  - Add/sub: C = carry out of bit WIDTH-1; V = signed overflow (operand signs equal and result sign differs, with B inverted for sub).
  - All other ops: C = V = 0.
- Flag register update: on an edge with rst = 1, enable = 1, flush = 0 and FlagEn = 1, flags take the new NZCV. Otherwise flags hold.
- EX/MEM latch (single cycle; inputs at edge k appear at outputs after edge k):
  - enable = 1, flush = 0: latch all outputs.
  - flush = 1 (regardless of enable): cntrl_M_out, cntrl_WB_out, Rd_out, alu_out, store_data, br_target and zero_out all load 0. Flags do not update. Flush has priority over stall.
  - enable = 0, flush = 0: every output and the flags hold.
- Forward path 01 uses the currently latched alu_out, i.e. the previous instruction's result; combinational loop-free.
- Arithmetic is unsigned modulo 2^WIDTH; no exceptions.

Test Plan:
- rst low mid-operation with stored nonzero values → all outputs and flags read 0 before the next clk edge; they stay 0 until the first edge after release.
- RD1 = 5, RD2 = 7, ALUOp = 010, FlagEn = 1, enable = 1 → alu_out = 12, zero_out = 0, flags = 0000 one cycle later.
- A = 0x7FFF_FFFF_FFFF_FFFF, B = 1, ALUOp = 010, FlagEn = 1 → alu_out = 0x8000_0000_0000_0000, flags N = 1, V = 1, C = 0. Then A = B = 3, ALUOp = 011 → alu_out = 0, flags Z = 1, C = 1.
- Back-to-back: first instruction gives alu_out = 12; next has fwdA = 01, RD1 = 99 (stale), se = 4, ALUsrc = 1, ALUOp = 010 → alu_out = 16. With fwdB = 10 and wb_data = 0x20, store_data = 0x20.
- enable = 0 for 3 cycles while inputs change → all outputs and flags unchanged. Then flush = 1 with enable = 0 → cntrl_M_out = 0, cntrl_WB_out = 0, Rd_out = 0, flags unchanged even if FlagEn = 1.
- PCaddr = 0x100, se = -2, ALUOp = 111, ShiftDir = 1, A = 0x80, B = 3 via ALUsrc = 0 → br_target = 0xF8, alu_out = 0x10, flags C = V = 0 if FlagEn = 1.
